// File: rtl/player_move_ctrl.sv
// Player movement scheduler: scans every maze rectangle for edge contact, then commits or refuses a 1-px move.
// Optional build macro COLOR_PASS_EN: rectangles matching the player colour never block.
module player_move_ctrl #(
   parameter int unsigned NUM_RECTS   = 4,
   parameter int unsigned IDX_W       = 2,
   parameter int unsigned PLAYER_SIZE = 12,
   parameter int unsigned H_MAX       = 640,
   parameter int unsigned V_MAX       = 480,
   parameter int unsigned START_H     = 314,
   parameter int unsigned START_V     = 234
) (
   input  logic             btnClk,
   input  logic             rst,
   input  logic [3:0]       btns,
   input  logic [3:0]       player_color,
   output logic [IDX_W-1:0] rect_sel,
   input  logic [31:0]      rect_hPos,
   input  logic [31:0]      rect_vPos,
   input  logic [31:0]      rect_width,
   input  logic [31:0]      rect_height,
   input  logic [3:0]       rect_color,
   output logic [31:0]      player_hPos,
   output logic [31:0]      player_vPos,
   output logic [3:0]       blocked,
   output logic             busy,
   output logic             move_done
);

   localparam int unsigned POS_W = 32;
   localparam logic [POS_W-1:0] P_SZ  = POS_W'(PLAYER_SIZE);
   localparam logic [POS_W-1:0] H_LIM = POS_W'(H_MAX - PLAYER_SIZE);
   localparam logic [POS_W-1:0] V_LIM = POS_W'(V_MAX - PLAYER_SIZE);
   localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_RECTS - 1);
`ifdef COLOR_PASS_EN
   localparam logic COLOR_PASS = 1'b1;
`else
   localparam logic COLOR_PASS = 1'b0;
`endif

   localparam logic [3:0] DIR_U = 4'b1000;
   localparam logic [3:0] DIR_D = 4'b0100;
   localparam logic [3:0] DIR_R = 4'b0010;
   localparam logic [3:0] DIR_L = 4'b0001;

   typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

   state_t           state, stateNext;
   logic [3:0]       dir, dirNext;
   logic             hit, hitNext;
   logic [IDX_W-1:0] selNext;
   logic [POS_W-1:0] hPosNext, vPosNext;
   logic [3:0]       blockedNext;
   logic             busyNext, moveDoneNext;
   logic             hOverlap, vOverlap, rectHit;

   // Edge-contact test of the currently presented rectangle against the latched direction
   always_comb begin
      hOverlap = (player_hPos < rect_hPos + rect_width) && (player_hPos + P_SZ > rect_hPos);
      vOverlap = (player_vPos < rect_vPos + rect_height) && (player_vPos + P_SZ > rect_vPos);
      rectHit  = 1'b0;
      if (rect_width != '0 && rect_height != '0 && !(COLOR_PASS && rect_color == player_color)) begin
         case (dir)
            DIR_U:   rectHit = (player_vPos == rect_vPos + rect_height) && hOverlap;
            DIR_D:   rectHit = (player_vPos + P_SZ == rect_vPos) && hOverlap;
            DIR_L:   rectHit = (player_hPos == rect_hPos + rect_width) && vOverlap;
            DIR_R:   rectHit = (player_hPos + P_SZ == rect_hPos) && vOverlap;
            default: rectHit = 1'b0;
         endcase
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      stateNext    = state;
      dirNext      = dir;
      hitNext      = hit;
      selNext      = rect_sel;
      hPosNext     = player_hPos;
      vPosNext     = player_vPos;
      blockedNext  = blocked;
      busyNext     = busy;
      moveDoneNext = 1'b0;
      case (state)
         IDLE: begin
            busyNext = 1'b0;
            if (btns == DIR_U || btns == DIR_D || btns == DIR_R || btns == DIR_L) begin
               dirNext   = btns;
               hitNext   = 1'b0;
               selNext   = '0;
               busyNext  = 1'b1;
               stateNext = SCAN;
            end
         end
         SCAN: begin
            hitNext = hit | rectHit;
            if (rect_sel == LAST_SEL) stateNext = DECIDE;
            else                      selNext   = rect_sel + IDX_W'(1);
         end
         DECIDE: begin
            blockedNext  = hit ? dir : 4'b0000;
            moveDoneNext = 1'b1;
            busyNext     = 1'b0;
            stateNext    = IDLE;
            if (!hit) begin
               case (dir)
                  DIR_U:   vPosNext = (player_vPos == '0)    ? V_LIM : player_vPos - POS_W'(1);
                  DIR_D:   vPosNext = (player_vPos == V_LIM) ? '0    : player_vPos + POS_W'(1);
                  DIR_L:   hPosNext = (player_hPos == '0)    ? H_LIM : player_hPos - POS_W'(1);
                  DIR_R:   hPosNext = (player_hPos == H_LIM) ? '0    : player_hPos + POS_W'(1);
                  default: ;
               endcase
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         dir         <= 4'b0000;
         hit         <= 1'b0;
         rect_sel    <= '0;
         player_hPos <= POS_W'(START_H);
         player_vPos <= POS_W'(START_V);
         blocked     <= 4'b0000;
         busy        <= 1'b0;
         move_done   <= 1'b0;
      end else begin
         state       <= stateNext;
         dir         <= dirNext;
         hit         <= hitNext;
         rect_sel    <= selNext;
         player_hPos <= hPosNext;
         player_vPos <= vPosNext;
         blocked     <= blockedNext;
         busy        <= busyNext;
         move_done   <= moveDoneNext;
      end
   end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Randomized self-checking bench for player_move_ctrl against a rule-level contact/move model.
module tb_player_move_ctrl;

   localparam int unsigned NUM_RECTS = 4;
   localparam int unsigned IDX_W     = 2;
   localparam int unsigned P         = 12;
   localparam int unsigned H_MAX     = 640;
   localparam int unsigned V_MAX     = 480;
   localparam int unsigned START_H   = 314;
   localparam int unsigned START_V   = 234;
`ifdef COLOR_PASS_EN
   localparam bit COLOR_PASS = 1'b1;
`else
   localparam bit COLOR_PASS = 1'b0;
`endif

   logic             btnClk = 1'b0;
   logic             rst;
   logic [3:0]       btns;
   logic [3:0]       player_color;
   logic [IDX_W-1:0] rect_sel;
   logic [31:0]      rect_hPos, rect_vPos, rect_width, rect_height;
   logic [3:0]       rect_color;
   logic [31:0]      player_hPos, player_vPos;
   logic [3:0]       blocked;
   logic             busy, move_done;

   logic [31:0] rH [NUM_RECTS];
   logic [31:0] rV [NUM_RECTS];
   logic [31:0] rW [NUM_RECTS];
   logic [31:0] rHt[NUM_RECTS];
   logic [3:0]  rC [NUM_RECTS];
   logic [31:0] mH, mV;
   int nCompared = 0;
   int nMismatched = 0;

   always #5 btnClk = ~btnClk;

   always_comb begin
      rect_hPos   = rH[rect_sel];
      rect_vPos   = rV[rect_sel];
      rect_width  = rW[rect_sel];
      rect_height = rHt[rect_sel];
      rect_color  = rC[rect_sel];
   end

   player_move_ctrl #(
      .NUM_RECTS(NUM_RECTS), .IDX_W(IDX_W), .PLAYER_SIZE(P), .H_MAX(H_MAX),
      .V_MAX(V_MAX), .START_H(START_H), .START_V(START_V)
   ) dut (
      .btnClk(btnClk), .rst(rst), .btns(btns), .player_color(player_color),
      .rect_sel(rect_sel), .rect_hPos(rect_hPos), .rect_vPos(rect_vPos),
      .rect_width(rect_width), .rect_height(rect_height), .rect_color(rect_color),
      .player_hPos(player_hPos), .player_vPos(player_vPos), .blocked(blocked),
      .busy(busy), .move_done(move_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Rule-level model: any touching, non-passable, non-empty rectangle blocks; otherwise step modulo the legal range
   task automatic modelStep(input logic [3:0] d, output logic [31:0] nh, output logic [31:0] nv,
                            output logic [3:0] nb);
      longint ph = longint'(mH);
      longint pv = longint'(mV);
      longint hr = longint'(H_MAX - P + 1);
      longint vr = longint'(V_MAX - P + 1);
      bit hitAny = 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         longint x = longint'(rH[i]);
         longint y = longint'(rV[i]);
         longint w = longint'(rW[i]);
         longint h = longint'(rHt[i]);
         bit hov = (ph < x + w) && (ph + P > x);
         bit vov = (pv < y + h) && (pv + P > y);
         bit skip = (w == 0) || (h == 0) || (COLOR_PASS && rC[i] == player_color);
         if (!skip) begin
            if (d == 4'd8 && pv == y + h && hov) hitAny = 1'b1;
            if (d == 4'd4 && pv + P == y && hov) hitAny = 1'b1;
            if (d == 4'd1 && ph == x + w && vov) hitAny = 1'b1;
            if (d == 4'd2 && ph + P == x && vov) hitAny = 1'b1;
         end
      end
      nh = mH;
      nv = mV;
      nb = hitAny ? d : 4'd0;
      if (!hitAny) begin
         if (d == 4'd8) nv = 32'((pv + vr - 1) % vr);
         if (d == 4'd4) nv = 32'((pv + 1) % vr);
         if (d == 4'd1) nh = 32'((ph + hr - 1) % hr);
         if (d == 4'd2) nh = 32'((ph + 1) % hr);
      end
   endtask

   task automatic doMove(input logic [3:0] code);
      logic [31:0] eh, ev;
      logic [3:0]  eb;
      int edges;
      modelStep(code, eh, ev, eb);
      btns = code;
      @(posedge btnClk); #1;
      btns = 4'd0;
      check("busy_start", 32'(busy), 32'd1);
      edges = 0;
      while (!move_done && edges < 20) begin
         if (edges < NUM_RECTS) check("rect_sel", 32'(rect_sel), 32'(edges));
         @(posedge btnClk); #1;
         edges++;
      end
      check("latency", 32'(edges), 32'(NUM_RECTS + 1));
      check("hPos", player_hPos, eh);
      check("vPos", player_vPos, ev);
      check("blocked", 32'(blocked), 32'(eb));
      check("busy_done", 32'(busy), 32'd0);
      mH = eh;
      mV = ev;
      @(posedge btnClk); #1;
      check("pulse_width", 32'(move_done), 32'd0);
   endtask

   task automatic farRects();
      for (int i = 0; i < NUM_RECTS; i++) begin
         rH[i] = 32'd600; rV[i] = 32'd0; rW[i] = 32'd10; rHt[i] = 32'd10; rC[i] = 4'd0;
      end
   endtask

   task automatic doReset();
      @(negedge btnClk);
      rst = 1'b0;
      @(posedge btnClk); #1;
      rst = 1'b1;
      mH = 32'(START_H);
      mV = 32'(START_V);
   endtask

   // Places each rectangle far away, degenerate, or touching a random side of the model player
   task automatic randRects();
      for (int i = 0; i < NUM_RECTS; i++) begin
         int unsigned mode = $urandom_range(0, 3);
         int unsigned w = $urandom_range(1, 20);
         int unsigned h = $urandom_range(1, 20);
         int unsigned side = $urandom_range(0, 3);
         int unsigned nearH = (mH >= 10) ? mH - 10 + $urandom_range(0, 20) : $urandom_range(0, 20);
         int unsigned nearV = (mV >= 10) ? mV - 10 + $urandom_range(0, 20) : $urandom_range(0, 20);
         rC[i] = 4'($urandom_range(0, 3));
         if (mode == 0) begin
            rH[i] = $urandom_range(0, 600); rV[i] = $urandom_range(0, 440);
         end else if (mode == 1) begin
            if ($urandom_range(0, 1) == 1) w = 0; else h = 0;
            rH[i] = mH + P; rV[i] = mV;
         end else begin
            case (side)
               0: begin if (mV < h) h = mV; rV[i] = mV - h; rH[i] = nearH; end
               1: begin rV[i] = mV + P; rH[i] = nearH; end
               2: begin if (mH < w) w = mH; rH[i] = mH - w; rV[i] = nearV; end
               default: begin rH[i] = mH + P; rV[i] = nearV; end
            endcase
         end
         rW[i] = w;
         rHt[i] = h;
      end
      player_color = 4'($urandom_range(0, 3));
   endtask

   initial begin
      logic [3:0] code;
      int guard;
      rst = 1'b1;
      btns = 4'd0;
      player_color = 4'd3;
      farRects();
      #3 rst = 1'b0;
      @(posedge btnClk); @(posedge btnClk); #1;
      check("rst_hPos", player_hPos, 32'd314);
      check("rst_vPos", player_vPos, 32'd234);
      check("rst_blocked", 32'(blocked), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_move_done", 32'(move_done), 32'd0);
      check("rst_rect_sel", 32'(rect_sel), 32'd0);
      @(negedge btnClk) rst = 1'b1;
      mH = 32'(START_H);
      mV = 32'(START_V);

      // Free move right
      doMove(4'd2);
      check("free_h", player_hPos, 32'd315);
      check("free_v", player_vPos, 32'd234);
      check("free_blocked", 32'(blocked), 32'd0);

      // Right wall contact, different then same colour
      doReset();
      rH[2] = 32'd326; rV[2] = 32'd230; rW[2] = 32'd20; rHt[2] = 32'd20; rC[2] = 4'd5;
      doMove(4'd2);
      check("block_h", player_hPos, 32'd314);
      check("block_dir", 32'(blocked), 32'd2);
      rC[2] = 4'd3;
      doMove(4'd2);
      check("pass_h", player_hPos, COLOR_PASS ? 32'd315 : 32'd314);
      check("pass_dir", 32'(blocked), COLOR_PASS ? 32'd0 : 32'd2);

      // Wrap at top and right edges
      farRects();
      guard = 0;
      while (mV != 0 && guard < 500) begin doMove(4'd8); guard++; end
      doMove(4'd8);
      check("wrap_up", player_vPos, 32'd468);
      guard = 0;
      while (mH != 32'(H_MAX - P) && guard < 700) begin doMove(4'd2); guard++; end
      doMove(4'd2);
      check("wrap_right", player_hPos, 32'd0);

      // Multi-bit buttons are ignored
      @(negedge btnClk) btns = 4'b1010;
      for (int i = 0; i < 10; i++) begin
         @(posedge btnClk); #1;
         check("illegal_busy", 32'(busy), 32'd0);
         check("illegal_done", 32'(move_done), 32'd0);
      end
      btns = 4'd0;
      check("illegal_h", player_hPos, mH);
      check("illegal_v", player_vPos, mV);

      // Randomized moves near walls
      for (int n = 0; n < 80; n++) begin
         randRects();
         if ($urandom_range(0, 5) == 0) begin
            do code = 4'($urandom_range(0, 15));
            while (code == 4'd8 || code == 4'd4 || code == 4'd2 || code == 4'd1);
            btns = code;
            @(posedge btnClk); #1;
            btns = 4'd0;
            check("rand_illegal_busy", 32'(busy), 32'd0);
         end else begin
            case ($urandom_range(0, 3))
               0: code = 4'd8;
               1: code = 4'd4;
               2: code = 4'd2;
               default: code = 4'd1;
            endcase
            doMove(code);
         end
      end

      // Reset during scan aborts the move
      farRects();
      doReset();
      doMove(4'd4);
      btns = 4'd4;
      @(posedge btnClk); #1;
      btns = 4'd0;
      @(posedge btnClk); @(posedge btnClk); #1;
      check("midscan_sel", 32'(rect_sel), 32'd2);
      rst = 1'b0;
      #1;
      check("midscan_rst_h", player_hPos, 32'd314);
      check("midscan_rst_v", player_vPos, 32'd234);
      check("midscan_rst_busy", 32'(busy), 32'd0);
      check("midscan_rst_sel", 32'(rect_sel), 32'd0);
      @(negedge btnClk) rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge btnClk); #1;
         check("midscan_no_done", 32'(move_done), 32'd0);
         check("midscan_no_busy", 32'(busy), 32'd0);
      end
      check("midscan_final_v", player_vPos, 32'd234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
Movement scheduler for the player square in the rectangle maze.
- Once per button sample, it steps a shared rectangle-descriptor mux through all NUM_RECTS rectangles, one per cycle.
- It checks each rectangle for edge contact against the player in the requested direction, then commits or refuses a one-pixel move.
- It owns the player position registers and is the only block that updates player_hPos/player_vPos.

Parameters:
NUM_RECTS, 4, number of rectangles scanned per move
IDX_W, 2, width of rect_sel; must satisfy 2^IDX_W >= NUM_RECTS
PLAYER_SIZE, 12, player square edge in pixels
H_MAX, 640, screen width in pixels
V_MAX, 480, screen height in pixels
START_H, 314, player hPos after reset (must be ≤ H_MAX-PLAYER_SIZE)
START_V, 234, player vPos after reset (must be ≤ V_MAX-PLAYER_SIZE)

Ports:
btnClk  input  1  movement clock, rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
btns  input  4  {U,D,R,L}; valid codes 8,4,2,1
player_color  input  4  current player colour
rect_sel  output  IDX_W  index of rectangle presented on rect_* this cycle
rect_hPos  input  32  effective left edge of selected rectangle (start+offset), combinational from rect_sel
rect_vPos  input  32  effective top edge of selected rectangle
rect_width  input  32  selected rectangle width
rect_height  input  32  selected rectangle height
rect_color  input  4  selected rectangle colour
player_hPos  output  32  player left edge
player_vPos  output  32  player top edge
blocked  output  4  {U,D,R,L} result of the last decision
busy  output  1  high while SCAN/DECIDE
move_done  output  1  one-cycle pulse at end of every decision, moved or not

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, player_hPos=START_H, player_vPos=START_V, blocked=0, busy=0, move_done=0, rect_sel=0, hit accumulator=0. A reset in any state aborts the scan; no position change occurs.
- States: IDLE, SCAN, DECIDE.
- IDLE: on each edge, if btns is one-hot (8/4/2/1):
  - latch direction into dir;
  - clear hit;
  - rect_sel←0;
  - go to SCAN.
  Any other btns value (0 or multi-bit) keeps IDLE. move_done=0, busy=0.
- SCAN: busy=1. Each cycle evaluates the rect_* inputs for rect_sel and ORs the result into hit.
  - If rect_sel==NUM_RECTS-1, go to DECIDE; else rect_sel+1.
  - Exactly NUM_RECTS cycles. btns changes are ignored; dir is held.
- Contact tests (P=PLAYER_SIZE; all arithmetic 32-bit unsigned; overlap comparisons strict):
  - hOverlap = player_hPos < rect_hPos+rect_width AND player_hPos+P > rect_hPos.
  - vOverlap = player_vPos < rect_vPos+rect_height AND player_vPos+P > rect_vPos.
  - U: player_vPos == rect_vPos+rect_height AND hOverlap.
  - D: player_vPos+P == rect_vPos AND hOverlap.
  - L: player_hPos == rect_hPos+rect_width AND vOverlap.
  - R: player_hPos+P == rect_hPos AND vOverlap.
  - A rectangle with rect_width==0 or rect_height==0 never hits.
- DECIDE (one cycle; busy=1 during it): on the edge leaving DECIDE:
  - blocked←dir if hit, else 0.
  - If not hit, move 1 px in dir with wrap:
    - U: vPos==0 → V_MAX-P, else vPos-1.
    - D: vPos==V_MAX-P → 0, else vPos+1.
    - L: hPos==0 → H_MAX-P, else hPos-1.
    - R: hPos==H_MAX-P → 0, else hPos+1.
  - move_done←1 for exactly one cycle; go to IDLE.
- Latency: button sampled at edge k. Position, blocked and move_done update at edge k+NUM_RECTS+1. The next sample is possible at edge k+NUM_RECTS+2, so a held button auto-repeats with that period.
- Position always stays within [0,H_MAX-P]×[0,V_MAX-P].

Optional Feature:
COLOR_PASS_EN
- Defined: a rectangle whose rect_color==player_color never contributes to hit (same-colour walls are passable).
- Undefined: player_color is ignored and every rectangle blocks on contact.

Test Plan:
1. Reset: hold rst=0 → player (314,234), blocked=0, busy=0, move_done=0, rect_sel=0.
2. Free move: all rects at (600,0) 10×10; btns=2 for one edge → rect_sel 0,1,2,3 on successive cycles; after 6 edges hPos=315, vPos=234, blocked=0, move_done pulses once.
3. Right block: rect2=(326,230) 20×20, colour 5; player colour 3 at (314,234); btns=2 → hPos stays 314, blocked=4'b0010. Same case with rect colour 3 under COLOR_PASS_EN → hPos=315, blocked=0.
4. Wrap: player at (314,0), no contacts, btns=8 → vPos=468. Player at (628,100), btns=2 → hPos=0.
5. Illegal buttons: btns=4'b1010 for 10 edges → busy stays 0, position unchanged, no move_done.
6. Reset mid-scan: btns=4, drive rst=0 during SCAN with rect_sel=2 → immediate reset values, state IDLE; after release, no pending move is applied.
